sevenseg_scanner: RTL and testbench
===================================

# sevenseg_scanner

Time-multiplexed driver for the Nexys4 eight-digit seven-segment display. It sits directly downstream of the PicoBlaze register interface and consumes that block's digit registers (DIG0–DIG7) and decimal-point registers (DP 3:0, DP 7:4). It drives the active-low anode, segment and decimal-point pins. Input values are captured once per frame into shadow registers, so PicoBlaze writes never tear a frame.

## Interface
- REFRESH_CYCLES, 50000: sysclk cycles per digit slot; legal range ≥ 2.
- BLANK_CYCLES, 8: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 ≤ BLANK_CYCLES < REFRESH_CYCLES.
- sysclk  in  1  system clock; all state changes on the rising edge.
- sysreset  in  1  reset; asynchronous, active-low.
- dig0 … dig7  in  8 each  digit codes (dig0 = rightmost); driven from PORT_06…PORT_03 and PORT_16…PORT_13.
- dp_lo  in  4  decimal points for digits 3:0, active-high (from PORT_07).
- dp_hi  in  4  decimal points for digits 7:4, active-high (from PORT_17 bits 3:0).
- digit_en  in  8  per-digit enable; 0 keeps that anode off.
- an  out  8  anodes, active-low; an[i] selects digit i.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse on the edge that reloads the shadow registers.

## Operation
- Slot counter cnt counts 0 … REFRESH_CYCLES−1.
  - Its width is the smallest width that holds REFRESH_CYCLES−1.
  - When cnt = REFRESH_CYCLES−1: cnt ← 0 and idx ← idx+1, where idx is a 3-bit digit index that wraps 7 → 0.
- Shadow load happens on the edge where cnt = REFRESH_CYCLES−1 and idx = 7.
  - Loads sh_dig[0..7] ← dig0..dig7, sh_dp ← {dp_hi, dp_lo} and sh_en ← digit_en.
  - frame_tick = 1 for exactly that one cycle; otherwise 0.
- Input changes at any other time have no visible effect until the next shadow load.
- Glyph decode of sh_dig[idx], given as active-low {g..a}:
  - 0x00–0x0F give hex glyphs: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
  - 0x11 gives dash 0x3F.
  - 0x10 and all other codes give blank 0x7F.
- Output rule, registered and evaluated from the cnt/idx of the current cycle:
  - an = 8'hFF if cnt < BLANK_CYCLES or sh_en[idx] = 0; otherwise an = ~(8'b1 << idx).
  - seg = decode(sh_dig[idx]) whenever an ≠ 8'hFF; otherwise seg = 7'h7F.
  - dp = ~sh_dp[idx] whenever an ≠ 8'hFF; otherwise dp = 1.
- At most one anode is low in any cycle.

## Timing
- Reset (asynchronous assert, any cycle):
  - cnt = 0, idx = 0, frame_tick = 0.
  - an = 8'hFF, seg = 7'h7F, dp = 1.
  - sh_dig = 8'h10 (blank) for all digits, sh_dp = 0, sh_en = 0.
- Reset deassertion is synchronous to sysclk by system design. The first post-reset frame is therefore dark.
- First shadow load: 8·REFRESH_CYCLES cycles after the first active edge.
- Output latency: one cycle. Outputs in cycle t+1 reflect cnt, idx and shadows in cycle t.
- Shadow loads use their new values starting the cycle after frame_tick, i.e. slot idx=0, cnt=0 → visible at cycle +1.
- Frame period: exactly 8·REFRESH_CYCLES cycles. frame_tick is periodic with that period and never misses.
- BLANK_CYCLES = 0: no dark gap; anodes switch directly between digits.
- Reset mid-frame: outputs go dark immediately and shadows revert to blank. No partial frame continues.

## Test plan
All scenarios use REFRESH_CYCLES=4 and BLANK_CYCLES=1.

- **Reset values.** Hold sysreset=0 with random inputs → an=FF, seg=7F, dp=1, frame_tick=0 throughout. After release, the display stays dark for 32 cycles. frame_tick pulses at cycle 32, then every 32 cycles.
- **Basic scan.** dig0..7 = 0..7, digit_en=FF, dp_lo=4'b0001, dp_hi=0 → after the first tick, each slot shows 1 dark cycle then 3 lit cycles. Expected values:
  - idx0: an=FE, seg=40, dp=0.
  - idx1: an=FD, seg=79, dp=1.
  - idx7: an=7F, seg=78, dp=1.
- **Tear-free update.** Change dig3 from 0x03 to 0x0E mid-frame → the slot-3 output stays 0x30 until after the next frame_tick, then becomes 0x06.
- **Decode edges.** dig0 = 0x10, 0x11, 0xFF, 0x0F in successive frames → seg = 7F, 3F, 7F, 0E during lit cycles of slot 0.
- **Enable mask.** digit_en=8'b1010_1010 → slots 0/2/4/6 show an=FF, seg=7F, dp=1; odd slots light normally.
- **Async reset mid-frame.** Assert sysreset during slot 5 while lit → an=FF on the same edge, without waiting for sysclk. After release, the next frame is blank and the counters restart at idx0.

Source files
------------

// File: rtl/sevenseg_scanner.sv
// -----------------------------------------------------------------------------
// sevenseg_scanner
//
// Time-multiplexed driver for the Nexys4 eight-digit seven-segment display.
// Each of the eight digits owns one slot of REFRESH_CYCLES sysclk cycles. The
// first BLANK_CYCLES cycles of every slot keep all anodes off so the previous
// digit's segment pattern cannot ghost onto the next anode.
//
// The digit codes, decimal points and enables coming from the PicoBlaze
// register interface are captured into shadow registers once per frame, on
// the last cycle of slot 7. A frame is therefore always drawn from one
// consistent snapshot, however the processor writes its registers.
//
// Parameters
//   REFRESH_CYCLES  sysclk cycles per digit slot (>= 2)
//   BLANK_CYCLES    dark cycles at the start of each slot (< REFRESH_CYCLES)
//
// Ports
//   sysclk      in   system clock, rising edge active
//   sysreset    in   asynchronous reset, active-low
//   dig0..dig7  in   8-bit digit codes, dig0 is the rightmost digit
//   dp_lo       in   decimal points for digits 3:0, active-high
//   dp_hi       in   decimal points for digits 7:4, active-high
//   digit_en    in   per-digit enable, 0 keeps that anode off
//   an          out  anodes, active-low, an[i] selects digit i
//   seg         out  segments, active-low, seg[0]=a .. seg[6]=g
//   dp          out  decimal point, active-low
//   frame_tick  out  high during the cycle whose closing edge reloads shadows
//
// Digit codes 0x00-0x0F show the hex glyph, 0x11 shows a dash and every
// other code (0x10 in particular) shows a blank digit.
// -----------------------------------------------------------------------------
module sevenseg_scanner #(
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLANK_CYCLES   = 8
) (
  input  logic       sysclk,
  input  logic       sysreset,
  input  logic [7:0] dig0,
  input  logic [7:0] dig1,
  input  logic [7:0] dig2,
  input  logic [7:0] dig3,
  input  logic [7:0] dig4,
  input  logic [7:0] dig5,
  input  logic [7:0] dig6,
  input  logic [7:0] dig7,
  input  logic [3:0] dp_lo,
  input  logic [3:0] dp_hi,
  input  logic [7:0] digit_en,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  // Smallest counter width that can hold REFRESH_CYCLES-1.
  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [2:0]       IDX_LAST  = 3'd7;

  // Code loaded into every shadow digit at reset; decodes to a blank glyph.
  localparam logic [7:0] CODE_BLANK = 8'h10;

  // Dark output values (everything active-low).
  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // ---------------------------------------------------------------------------
  // Glyph decode: returns active-low {g,f,e,d,c,b,a}.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] glyph(input logic [7:0] code);
    logic [6:0] g;
    g = SEG_OFF;
    case (code)
      8'h00: g = 7'h40;
      8'h01: g = 7'h79;
      8'h02: g = 7'h24;
      8'h03: g = 7'h30;
      8'h04: g = 7'h19;
      8'h05: g = 7'h12;
      8'h06: g = 7'h02;
      8'h07: g = 7'h78;
      8'h08: g = 7'h00;
      8'h09: g = 7'h10;
      8'h0A: g = 7'h08;
      8'h0B: g = 7'h03;
      8'h0C: g = 7'h46;
      8'h0D: g = 7'h21;
      8'h0E: g = 7'h06;
      8'h0F: g = 7'h0E;
      8'h11: g = 7'h3F;  // dash
      default: g = SEG_OFF;
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------------------
  // Gather the digit inputs into an array so they can be loaded in a loop.
  // ---------------------------------------------------------------------------
  logic [7:0] dig_in [8];

  assign dig_in[0] = dig0;
  assign dig_in[1] = dig1;
  assign dig_in[2] = dig2;
  assign dig_in[3] = dig3;
  assign dig_in[4] = dig4;
  assign dig_in[5] = dig5;
  assign dig_in[6] = dig6;
  assign dig_in[7] = dig7;

  // ---------------------------------------------------------------------------
  // Slot counter and digit index
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             slot_end;
  logic             frame_end;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others, regardless of the
  // order the statements appear in.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 3'd1;  // wraps 7 -> 0 by width
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // The reload edge is the one that closes the last cycle of slot 7; the tick
  // is a decode of the counter registers, so it is high for exactly that
  // cycle and low while reset holds cnt at zero.
  assign frame_tick = frame_end;

  // ---------------------------------------------------------------------------
  // Shadow registers, reloaded once per frame
  // ---------------------------------------------------------------------------
  logic [7:0] sh_dig [8];
  logic [7:0] sh_dp;
  logic [7:0] sh_en;

  // NOTE: the shadow digit array is reset explicitly because a mid-frame reset
  // must drop the old snapshot; this is only eight registers, not a RAM, so
  // resetting every entry is cheap and keeps it out of block memory inference.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      for (int i = 0; i < 8; i++) begin
        sh_dig[i] <= CODE_BLANK;
      end
      sh_dp <= '0;
      sh_en <= '0;
    end else if (frame_end) begin
      for (int i = 0; i < 8; i++) begin
        sh_dig[i] <= dig_in[i];
      end
      sh_dp <= {dp_hi, dp_lo};
      sh_en <= digit_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Output selection for the current cycle, registered below
  // ---------------------------------------------------------------------------
  logic       in_blank;
  logic       lit;
  logic [7:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  // NOTE: every signal written in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    in_blank = 1'b0;
    lit      = 1'b0;
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;

    // With BLANK_CYCLES = 0 the window is empty and anodes switch directly.
    if (BLANK_CYCLES != 0) begin
      in_blank = (cnt < CNT_BLANK);
    end

    lit = !in_blank && sh_en[idx];

    // Only one anode can be low: it is a single bit shifted by idx.
    if (lit) begin
      an_next  = ~(8'b1 << idx);
      seg_next = glyph(sh_dig[idx]);
      dp_next  = ~sh_dp[idx];
    end
  end

  // Registered outputs: one cycle behind cnt/idx, dark during reset.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scanner
//
// Directed bench for sevenseg_scanner with REFRESH_CYCLES=4, BLANK_CYCLES=1.
// Outputs are sampled on the falling edge of sysclk. Positions inside a frame
// are counted in falling edges after the one where frame_tick is seen high;
// with a one-cycle output latency, slot k is dark at position 2+4k and lit at
// positions 3+4k .. 5+4k.
// -----------------------------------------------------------------------------
module tb_sevenseg_scanner;

  logic       sysclk;
  logic       sysreset;
  logic [7:0] dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7;
  logic [3:0] dp_lo;
  logic [3:0] dp_hi;
  logic [7:0] digit_en;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;
  int pos    = 0;

  sevenseg_scanner #(
    .REFRESH_CYCLES(4),
    .BLANK_CYCLES  (1)
  ) dut (
    .sysclk    (sysclk),
    .sysreset  (sysreset),
    .dig0      (dig0),
    .dig1      (dig1),
    .dig2      (dig2),
    .dig3      (dig3),
    .dig4      (dig4),
    .dig5      (dig5),
    .dig6      (dig6),
    .dig7      (dig7),
    .dp_lo     (dp_lo),
    .dp_hi     (dp_hi),
    .digit_en  (digit_en),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_an,
                           input logic [6:0] e_seg, input logic e_dp);
    check({tag, ".an"},  an,          e_an);
    check({tag, ".seg"}, {1'b0, seg}, {1'b0, e_seg});
    check({tag, ".dp"},  {7'd0, dp},  {7'd0, e_dp});
  endtask

  task automatic adv_to(input int target);
    while (pos < target) begin
      @(negedge sysclk);
      pos++;
    end
  endtask

  // Wait (bounded) for the next frame_tick and make it position 0.
  task automatic sync_tick(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge sysclk);
      if (frame_tick) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, ".tick_seen"}, {7'd0, found}, 8'd1);
    pos = 0;
  endtask

  // Called at the falling edge where reset is released: the whole first frame
  // must be dark and the tick must land on the 31st falling edge after it.
  task automatic dark_frame(input string tag);
    for (int i = 1; i <= 31; i++) begin
      @(negedge sysclk);
      check({tag, ".an"}, an, 8'hFF);
      check({tag, ".tick"}, {7'd0, frame_tick}, (i == 31) ? 8'd1 : 8'd0);
    end
    pos = 0;
  endtask

  initial begin
    sysreset = 1'b1;
    {dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7} = '0;
    dp_lo    = '0;
    dp_hi    = '0;
    digit_en = '0;
    #1 sysreset = 1'b0;

    // Reset held with random inputs: everything dark, no tick.
    for (int i = 0; i < 4; i++) begin
      dig0 = 8'($urandom); dig1 = 8'($urandom); dig2 = 8'($urandom);
      dig3 = 8'($urandom); dig4 = 8'($urandom); dig5 = 8'($urandom);
      dig6 = 8'($urandom); dig7 = 8'($urandom);
      dp_lo = 4'($urandom); dp_hi = 4'($urandom); digit_en = 8'($urandom);
      @(negedge sysclk);
      check_out("rst_hold", 8'hFF, 7'h7F, 1'b1);
      check("rst_hold.tick", {7'd0, frame_tick}, 8'd0);
    end

    // Basic scan inputs, then release reset.
    dig0 = 8'h00; dig1 = 8'h01; dig2 = 8'h02; dig3 = 8'h03;
    dig4 = 8'h04; dig5 = 8'h05; dig6 = 8'h06; dig7 = 8'h07;
    dp_lo = 4'b0001; dp_hi = 4'b0000; digit_en = 8'hFF;
    sysreset = 1'b1;
    dark_frame("first_frame");

    // Basic scan.
    adv_to(1);  check_out("scan.p1_old",   8'hFF, 7'h7F, 1'b1);
    adv_to(2);  check_out("scan.s0_dark",  8'hFF, 7'h7F, 1'b1);
    adv_to(3);  check_out("scan.s0_lit",   8'hFE, 7'h40, 1'b0);
    adv_to(5);  check_out("scan.s0_last",  8'hFE, 7'h40, 1'b0);
    adv_to(6);  check_out("scan.s1_dark",  8'hFF, 7'h7F, 1'b1);
    adv_to(7);  check_out("scan.s1_lit",   8'hFD, 7'h79, 1'b1);
    adv_to(15); check_out("scan.s3_lit",   8'hF7, 7'h30, 1'b1);
    adv_to(31); check_out("scan.s7_lit",   8'h7F, 7'h78, 1'b1);
    adv_to(32); check("scan.tick_period", {7'd0, frame_tick}, 8'd1);
    adv_to(33); check("scan.tick_width",  {7'd0, frame_tick}, 8'd0);
    pos = 1;

    // Tear-free update: change dig3 mid-frame.
    dig3 = 8'h0E;
    adv_to(15); check_out("tear.same_frame", 8'hF7, 7'h30, 1'b1);
    sync_tick("tear");
    adv_to(15); check_out("tear.next_frame", 8'hF7, 7'h06, 1'b1);

    // Decode edges on digit 0, one code per frame.
    dig0 = 8'h10; sync_tick("dec10"); adv_to(3); check_out("dec.code10", 8'hFE, 7'h7F, 1'b0);
    dig0 = 8'h11; sync_tick("dec11"); adv_to(3); check_out("dec.code11", 8'hFE, 7'h3F, 1'b0);
    dig0 = 8'hFF; sync_tick("decFF"); adv_to(3); check_out("dec.codeFF", 8'hFE, 7'h7F, 1'b0);
    dig0 = 8'h0F; sync_tick("dec0F"); adv_to(3); check_out("dec.code0F", 8'hFE, 7'h0E, 1'b0);

    // Enable mask: only odd digits light.
    dig0 = 8'h00;
    digit_en = 8'b1010_1010;
    sync_tick("en");
    adv_to(3);  check_out("en.s0_off", 8'hFF, 7'h7F, 1'b1);
    adv_to(7);  check_out("en.s1_on",  8'hFD, 7'h79, 1'b1);
    adv_to(11); check_out("en.s2_off", 8'hFF, 7'h7F, 1'b1);
    adv_to(15); check_out("en.s3_on",  8'hF7, 7'h06, 1'b1);
    adv_to(23); check_out("en.s5_on",  8'hDF, 7'h12, 1'b1);

    // Asynchronous reset while slot 5 is lit, away from any rising edge.
    #2 sysreset = 1'b0;
    #1;
    check_out("async_rst", 8'hFF, 7'h7F, 1'b1);
    check("async_rst.tick", {7'd0, frame_tick}, 8'd0);
    @(negedge sysclk);
    sysreset = 1'b1;
    dark_frame("post_rst");
    adv_to(3); check_out("post_rst.s0_off", 8'hFF, 7'h7F, 1'b1);
    adv_to(7); check_out("post_rst.s1_on",  8'hFD, 7'h79, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
